sl_preceptron_seq: RTL

Sequencer for the single-layer perceptron datapath. It sits downstream of the input FIFO, consumes the FIFO's serialized sample stream, and drives the weight-memory address. It performs a signed saturating multiply-accumulate over one input vector plus bias, then compares the sum against a threshold and emits a one-cycle classification result. It also guards against stalled streams (timeout) and stray samples (protocol error).

---
 rtl/sl_preceptron_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sl_preceptron_seq.sv
`default_nettype none
// ============================================================================
// sl_preceptron_seq : single-layer perceptron sequencer (saturating MAC + compare)
// Revision 1.0
// ============================================================================
module sl_preceptron_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 52,
    parameter int ACC_WIDTH  = 24,
    parameter int TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ACC_WIDTH-1:0]       bias,
    input  logic [ACC_WIDTH-1:0]       threshold,
    input  logic                       sample_valid,
    input  logic [DATA_WIDTH-1:0]      sample,
    output logic [$clog2(VEC_LEN)-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]      w_data,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       result,
    output logic [ACC_WIDTH-1:0]       acc_out,
    output logic                       sat,
    output logic                       err
);

    localparam int C_ADDR_W = $clog2(VEC_LEN);
    localparam int C_IDLE_W = $clog2(TIMEOUT + 1);
    localparam int C_PROD_W = 2 * DATA_WIDTH;

    localparam logic [C_ADDR_W-1:0]  C_LAST_IDX = C_ADDR_W'(VEC_LEN - 1);
    localparam logic [C_IDLE_W-1:0]  C_TO_LAST  = C_IDLE_W'(TIMEOUT - 1);
    localparam logic [ACC_WIDTH-1:0] C_ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] C_ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                r_state;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  r_thr;
    logic [C_ADDR_W-1:0]   r_cnt;
    logic [C_IDLE_W-1:0]   r_idle_cnt;
    logic                  r_busy;
    logic                  r_result_valid;
    logic                  r_result;
    logic                  r_sat;
    logic                  r_err;

    logic signed [C_PROD_W-1:0] w_sample_x;
    logic signed [C_PROD_W-1:0] w_weight_x;
    logic signed [C_PROD_W-1:0] w_prod;
    logic [ACC_WIDTH:0]         w_sum;
    logic                       w_ovf;
    logic [ACC_WIDTH-1:0]       w_acc_next;

    // Operands widened first so the product keeps its full 2*DATA_WIDTH range
    assign w_sample_x = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample};
    assign w_weight_x = {{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data};
    assign w_prod     = w_sample_x * w_weight_x;

    assign w_sum = {r_acc[ACC_WIDTH-1], r_acc}
                 + {{(ACC_WIDTH + 1 - C_PROD_W){w_prod[C_PROD_W-1]}}, w_prod};

    // One guard bit suffices: overflow shows as the two top bits disagreeing
    assign w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_acc_next = w_ovf ? (w_sum[ACC_WIDTH] ? C_ACC_MIN : C_ACC_MAX)
                              : w_sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_thr          <= '0;
            r_cnt          <= '0;
            r_idle_cnt     <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= 1'b0;
            r_sat          <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACCUM;
                        r_acc      <= bias;
                        r_thr      <= threshold;
                        r_cnt      <= '0;
                        r_idle_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_sat      <= 1'b0;
                        // A sample arriving with start is stray and is flagged
                        r_err      <= sample_valid;
                    end else if (sample_valid) begin
                        r_err <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (sample_valid) begin
                        r_acc      <= w_acc_next;
                        r_cnt      <= r_cnt + C_ADDR_W'(1);
                        r_idle_cnt <= '0;
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
                        if (r_cnt == C_LAST_IDX) begin
                            r_state <= S_COMPARE;
                        end
                    end else if (r_idle_cnt == C_TO_LAST) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_cnt      <= '0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + C_IDLE_W'(1);
                    end
                end
                S_COMPARE: begin
                    r_result       <= ($signed(r_acc) >= $signed(r_thr));
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= S_DONE;
                    if (sample_valid) begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    if (sample_valid) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_addr       = r_cnt;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign acc_out      = r_acc;
    assign sat          = r_sat;
    assign err          = r_err;

endmodule
`default_nettype wire
